// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg
// Shared definitions for the frame scheduler:
//   - state_t      : scheduler FSM states
//   - DEF_*        : default parameter values for frame_scheduler
//   - MAP/CLOUD/HERO : named layer indices
//   - pick_layer() : priority encoder returning the lowest set mask bit at or
//                    above a starting index, or -1 when there is none
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    READY
  } state_t;

  localparam int DEF_N_LAYERS = 3;
  localparam int DEF_LAYER_W  = 2;
  localparam int DEF_TIMEOUT  = 65535;

  localparam int MAP   = 0;
  localparam int CLOUD = 1;
  localparam int HERO  = 2;

  // Widest layer mask the priority encoder handles; callers zero-extend.
  localparam int MAX_LAYERS = 32;

  // Lowest set bit of mask whose index is >= from; -1 if none.
  function automatic int pick_layer(input logic [MAX_LAYERS-1:0] mask, input int from);
    int idx;
    idx = -1;
    for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// vs_edge_sync
// Two-flop synchroniser for the VGA vertical sync plus a falling-edge detector.
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous active-low reset
//   i_vs       raw VS (active-low pulse, unrelated timing)
//   o_vs_fall  high for one cycle after the synchronised VS goes 1 -> 0
module vs_edge_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_vs,
  output logic o_vs_fall
);

  logic r_vs_q;
  logic r_vs_qq;

  // Both flops reset to the idle (high) level so releasing reset while VS is
  // high can never look like a falling edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_vs_q  <= 1'b1;
      r_vs_qq <= 1'b1;
    end else begin
      r_vs_q  <= i_vs;
      r_vs_qq <= r_vs_q;
    end
  end

  assign o_vs_fall = r_vs_qq & ~r_vs_q;

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Per-frame sequencer for the double-buffered video path. Each frame it
// launches one render pass per enabled layer (ascending index) into the back
// buffer, and swaps front/back buffers only at a VS start that follows a
// completed frame. A VS start during rendering is reported as a dropped frame.
// Ports:
//   i_clk           system clock
//   i_reset_n       synchronous active-low reset
//   i_vs            VGA vertical sync, active low, synchronised internally
//   i_frame_en      allow new frames to start
//   i_layer_mask    enabled layers, latched at frame start
//   i_render_done   one-cycle pulse: current layer finished
//   o_render_start  one-cycle pulse launching the renderer
//   o_render_layer  layer being rendered
//   o_render_en     renderer owns the back-buffer write port
//   o_buffer_sel    buffer currently displayed
//   o_frame_drop    one-cycle pulse: VS start while frame unfinished
//   o_timeout_err   sticky render-timeout flag
//   o_frame_cnt     number of buffer swaps (wraps)
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int N_LAYERS = DEF_N_LAYERS,
  parameter int LAYER_W  = DEF_LAYER_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_vs,
  input  logic                i_frame_en,
  input  logic [N_LAYERS-1:0] i_layer_mask,
  input  logic                i_render_done,
  output logic                o_render_start,
  output logic [LAYER_W-1:0]  o_render_layer,
  output logic                o_render_en,
  output logic                o_buffer_sel,
  output logic                o_frame_drop,
  output logic                o_timeout_err,
  output logic [15:0]         o_frame_cnt
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t               r_state;
  logic [N_LAYERS-1:0]  r_mask;
  logic [CNT_W-1:0]     r_to_cnt;
  logic                 r_render_start;
  logic [LAYER_W-1:0]   r_render_layer;
  logic                 r_render_en;
  logic                 r_buffer_sel;
  logic                 r_frame_drop;
  logic                 r_timeout_err;
  logic [15:0]          r_frame_cnt;

  logic w_vs_fall;
  int   w_first_idx;  // first layer of a new frame (from the live mask input)
  int   w_next_idx;   // next layer above the current one in the latched mask
  logic w_timeout;

  vs_edge_sync u_vs_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_vs      (i_vs),
    .o_vs_fall (w_vs_fall)
  );

  always_comb begin
    w_first_idx = pick_layer(32'(i_layer_mask), 0);
    w_next_idx  = pick_layer(32'(r_mask), int'(r_render_layer) + 1);
    w_timeout   = (r_to_cnt == TO_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      r_mask         <= '0;
      r_to_cnt       <= '0;
      r_render_start <= 1'b0;
      r_render_layer <= '0;
      r_render_en    <= 1'b0;
      r_buffer_sel   <= 1'b0;
      r_frame_drop   <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_render_start <= 1'b0;
      r_frame_drop   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_vs_fall && i_frame_en) begin
            r_mask <= i_layer_mask;
            if (w_first_idx >= 0) begin
              r_state        <= START;
              r_render_layer <= LAYER_W'(w_first_idx);
              r_render_start <= 1'b1;
              r_render_en    <= 1'b1;
              r_to_cnt       <= '0;
            end else begin
              // An empty frame is complete at once and still swaps.
              r_state <= READY;
            end
          end
        end
        START: begin
          // DONE is ignored here; the renderer has only just been launched.
          r_state      <= BUSY;
          r_frame_drop <= w_vs_fall;
        end
        BUSY: begin
          r_frame_drop <= w_vs_fall;
          if (!w_timeout) r_to_cnt <= r_to_cnt + CNT_W'(1);
          if (i_render_done || w_timeout) begin
            // A DONE arriving on the last allowed cycle counts as success.
            if (w_timeout && !i_render_done) r_timeout_err <= 1'b1;
            if (w_next_idx >= 0) begin
              r_state        <= START;
              r_render_layer <= LAYER_W'(w_next_idx);
              r_render_start <= 1'b1;
              r_to_cnt       <= '0;
            end else begin
              r_state     <= READY;
              r_render_en <= 1'b0;
            end
          end
        end
        READY: begin
          if (w_vs_fall) begin
            r_buffer_sel <= ~r_buffer_sel;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            if (i_frame_en) begin
              r_mask <= i_layer_mask;
              // Zero mask: stay in READY so the next VS swaps again.
              if (w_first_idx >= 0) begin
                r_state        <= START;
                r_render_layer <= LAYER_W'(w_first_idx);
                r_render_start <= 1'b1;
                r_render_en    <= 1'b1;
                r_to_cnt       <= '0;
              end
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_render_start = r_render_start;
  assign o_render_layer = r_render_layer;
  assign o_render_en    = r_render_en;
  assign o_buffer_sel   = r_buffer_sel;
  assign o_frame_drop   = r_frame_drop;
  assign o_timeout_err  = r_timeout_err;
  assign o_frame_cnt    = r_frame_cnt;

endmodule
